// File: rtl/pc_pkg.sv
// Shared constants, width helpers and the next-PC source encoding for the
// program counter unit and its return-address stack.
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_HOLD,
        SRC_REDIR,
        SRC_CALLRET,
        SRC_CALL,
        SRC_RET,
        SRC_RET_EMPTY,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the branch/decode logic (master) and the PC unit (slave).
interface pc_unit_if #(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = 4
);
    import pc_pkg::*;

    // hit acts as the accept qualifier: redirect/call/ret only take effect on an
    // edge where hit=1, otherwise the master must keep presenting them. trap does not wait.
    logic                                hit;
    logic                                redirect;
    logic [AW-1:0]                       redirect_target;
    logic                                call;
    logic [AW-1:0]                       call_target;
    logic                                ret;
    logic                                trap;
    logic [AW-1:0]                       address;
    logic [ras_cnt_w(RAS_DEPTH)-1:0]     ras_count;
    logic                                ras_overflow;
    logic                                ras_underflow;

    modport master (
        output hit, redirect, redirect_target, call, call_target, ret, trap,
        input  address, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  hit, redirect, redirect_target, call, call_target, ret, trap,
        output address, ras_count, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: top-of-stack pointer plus count; a push on a
// full stack overwrites the oldest entry and sets a sticky overflow flag.
module pc_ras
    import pc_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        replace_i,
    input  logic [AW-1:0]               data_i,
    output logic [AW-1:0]               top_o,
    output logic [ras_cnt_w(DEPTH)-1:0] count_o,
    output logic                        overflow_o,
    output logic                        empty_o
);
    localparam int PW = ras_ptr_w(DEPTH);
    localparam int CW = ras_cnt_w(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (full) ovf_d   = 1'b1;
            else      count_d = count_q + CW'(1);
        end else if (pop_i && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage needs no reset: its contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push_i)         mem_q[ptr_d] <= data_i;
        else if (replace_i) mem_q[ptr_q] <= data_i;
    end

    assign top_o      = mem_q[ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Program counter: prioritised next-PC selection (trap, hold, redirect, call/ret,
// sequential), the registered fetch address and the RAS underflow pulse.
module pc_unit
    import pc_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            INC       = 4,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
    parameter logic [AW-1:0] TRAP_VEC  = AW'(TRAP_VEC_DEF),
    parameter int            RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  pc_if
);
    localparam int CW = ras_cnt_w(RAS_DEPTH);

    logic [AW-1:0] addr_q, addr_d;
    logic          unf_q;
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] ras_top;
    logic [CW-1:0] ras_count;
    logic          ras_ovf;
    logic          ras_empty;
    pc_src_e       src;

    assign seq_pc = addr_q + AW'(INC);

    // A combined call+ret on an empty stack degrades to a plain call.
    always_comb begin
        src = SRC_SEQ;
        if (pc_if.trap)                                   src = SRC_TRAP;
        else if (!pc_if.hit)                              src = SRC_HOLD;
        else if (pc_if.redirect)                          src = SRC_REDIR;
        else if (pc_if.call && pc_if.ret && !ras_empty)   src = SRC_CALLRET;
        else if (pc_if.call)                              src = SRC_CALL;
        else if (pc_if.ret && !ras_empty)                 src = SRC_RET;
        else if (pc_if.ret)                               src = SRC_RET_EMPTY;
    end

    always_comb begin
        addr_d = seq_pc;
        case (src)
            SRC_TRAP:      addr_d = TRAP_VEC;
            SRC_HOLD:      addr_d = addr_q;
            SRC_REDIR:     addr_d = pc_if.redirect_target;
            SRC_CALLRET:   addr_d = pc_if.call_target;
            SRC_CALL:      addr_d = pc_if.call_target;
            SRC_RET:       addr_d = ras_top;
            SRC_RET_EMPTY: addr_d = TRAP_VEC;
            default:       addr_d = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_VEC;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            unf_q  <= (src == SRC_RET_EMPTY);
        end
    end

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (src == SRC_CALL),
        .pop_i      (src == SRC_RET),
        .replace_i  (src == SRC_CALLRET),
        .data_i     (seq_pc),
        .top_o      (ras_top),
        .count_o    (ras_count),
        .overflow_o (ras_ovf),
        .empty_o    (ras_empty)
    );

    assign pc_if.address       = addr_q;
    assign pc_if.ras_count     = ras_count;
    assign pc_if.ras_overflow  = ras_ovf;
    assign pc_if.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// all scored against a queue-based reference model of the PC and return stack.
module tb_pc_unit;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] TRAP = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pc_unit_if #(.AW(AW), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .AW        (AW),
        .INC       (4),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (TRAP),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_if (bus)
    );

    always #5 clk = ~clk;

    // Reference model: unbounded-order queue trimmed from the oldest end.
    logic [31:0] m_addr;
    logic [31:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;
    logic [36:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic h, input logic r, input logic [31:0] rt,
                              input logic c, input logic [31:0] ct, input logic rr,
                              input logic t);
        logic [31:0] nxt;
        nxt   = m_addr + 32'd4;
        m_unf = 1'b0;
        if (t) m_addr = TRAP;
        else if (!h) m_addr = m_addr;
        else if (r) m_addr = rt;
        else if (c && rr && m_stk.size() > 0) begin
            m_stk[m_stk.size()-1] = nxt;
            m_addr = ct;
        end else if (c) begin
            m_stk.push_back(nxt);
            if (m_stk.size() > DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_addr = ct;
        end else if (rr && m_stk.size() > 0) m_addr = m_stk.pop_back();
        else if (rr) begin
            m_addr = TRAP;
            m_unf  = 1'b1;
        end else m_addr = nxt;
    endtask

    task automatic step(input logic h, input logic r, input logic [31:0] rt,
                        input logic c, input logic [31:0] ct, input logic rr,
                        input logic t);
        logic [36:0] e;
        bus.hit = h; bus.redirect = r; bus.redirect_target = rt;
        bus.call = c; bus.call_target = ct; bus.ret = rr; bus.trap = t;
        model_step(h, r, rt, c, ct, rr, t);
        exp_q.push_back({m_addr, 3'(m_stk.size()), m_ovf, m_unf});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("addr", 64'(bus.address), 64'(e[36:5]));
            check_eq("ras_count", 64'(bus.ras_count), 64'(e[4:2]));
            check_eq("ras_overflow", 64'(bus.ras_overflow), 64'(e[1]));
            check_eq("ras_underflow", 64'(bus.ras_underflow), 64'(e[0]));
        end
    endtask

    task automatic seq();                    step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic hold();                   step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic redir(input logic [31:0] a); step(1, 1, a, 0, 0, 0, 0); endtask
    task automatic do_call(input logic [31:0] a); step(1, 0, 0, 1, a, 0, 0); endtask
    task automatic do_ret();                 step(1, 0, 0, 0, 0, 1, 0); endtask

    task automatic model_reset();
        m_addr = 32'h0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_reset();
        bus.hit = 0; bus.redirect = 0; bus.redirect_target = 0;
        bus.call = 0; bus.call_target = 0; bus.ret = 0; bus.trap = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_addr", 64'(bus.address), 64'h0);
        check_eq("rst_count", 64'(bus.ras_count), 64'h0);
        check_eq("rst_ovf", 64'(bus.ras_overflow), 64'h0);
        check_eq("rst_unf", 64'(bus.ras_underflow), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Sequential advance and hold
        seq();  check_eq("seq_4", 64'(bus.address), 64'h4);
        seq();  check_eq("seq_8", 64'(bus.address), 64'h8);
        seq();  check_eq("seq_c", 64'(bus.address), 64'hC);
        hold(); hold(); check_eq("hold_c", 64'(bus.address), 64'hC);
        step(0, 1, 32'h300, 1, 32'h700, 0, 0);
        check_eq("hold_ignores_redir", 64'(bus.address), 64'hC);
        seq();  check_eq("seq_10", 64'(bus.address), 64'h10);

        // Redirect and trap priority
        redir(32'h200); check_eq("redir", 64'(bus.address), 64'h200);
        step(1, 1, 32'h300, 0, 0, 0, 1); check_eq("trap_over_redir", 64'(bus.address), 64'h80);
        step(0, 0, 0, 0, 0, 0, 1);       check_eq("trap_no_hit", 64'(bus.address), 64'h80);

        // Nested call/return
        redir(32'h100);
        do_call(32'h400); check_eq("call1", 64'(bus.address), 64'h400);
        check_eq("call1_cnt", 64'(bus.ras_count), 64'd1);
        seq();            check_eq("seq_404", 64'(bus.address), 64'h404);
        do_call(32'h800); check_eq("call2_cnt", 64'(bus.ras_count), 64'd2);
        do_ret();         check_eq("ret1", 64'(bus.address), 64'h408);
        do_ret();         check_eq("ret2", 64'(bus.address), 64'h104);
        check_eq("ret2_cnt", 64'(bus.ras_count), 64'd0);

        // Overflow then drain past empty
        redir(32'h0);
        do_call(32'h10); do_call(32'h20); do_call(32'h30); do_call(32'h40); do_call(32'h50);
        check_eq("ovf_flag", 64'(bus.ras_overflow), 64'd1);
        check_eq("ovf_cnt", 64'(bus.ras_count), 64'd4);
        do_ret(); check_eq("ovf_ret1", 64'(bus.address), 64'h44);
        do_ret(); check_eq("ovf_ret2", 64'(bus.address), 64'h34);
        do_ret(); check_eq("ovf_ret3", 64'(bus.address), 64'h24);
        do_ret(); check_eq("ovf_ret4", 64'(bus.address), 64'h14);
        do_ret(); check_eq("unf_addr", 64'(bus.address), 64'h80);
        check_eq("unf_pulse", 64'(bus.ras_underflow), 64'd1);
        seq();    check_eq("unf_clear", 64'(bus.ras_underflow), 64'd0);

        // Simultaneous call+ret replaces the top entry
        redir(32'h500);
        do_call(32'h600);
        step(1, 0, 0, 1, 32'h900, 1, 0);
        check_eq("callret_addr", 64'(bus.address), 64'h900);
        check_eq("callret_cnt", 64'(bus.ras_count), 64'd1);
        do_ret(); check_eq("callret_top", 64'(bus.address), 64'h604);

        // Address wrap then asynchronous reset between edges
        redir(32'hFFFF_FFFC);
        seq(); check_eq("wrap", 64'(bus.address), 64'h0);
        seq(); check_eq("post_wrap", 64'(bus.address), 64'h4);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_addr", 64'(bus.address), 64'h0);
        check_eq("async_rst_cnt", 64'(bus.ras_count), 64'h0);
        check_eq("async_rst_ovf", 64'(bus.ras_overflow), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic h, r, c, rr, t;
            logic [31:0] rt, ct;
            t  = ($urandom_range(0, 19) == 0);
            h  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 3) == 0);
            rt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            ct = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            step(h, r, rt, c, ct, rr, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-register program counter of the 32-bit RISC core.
- Holds the fetch address and advances it by a fixed increment when fetch hits; otherwise holds.
- Adds over the earlier block: reset vector, branch/jump redirect, trap vectoring, and a circular return-address stack (RAS) for call/return.
- Sits between the branch/decode logic and the instruction cache; its output drives the I-cache address directly.

Parameters:
- AW, 32, address width in bits.
- INC, 4, sequential increment in bytes.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- TRAP_VEC, 32'h0000_0080, PC value on trap or RAS underflow.
- RAS_DEPTH, 4, return-address stack entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hit  in  1  fetch accepted; PC may advance this cycle.
- redirect  in  1  branch/jump taken.
- redirect_target  in  AW  target for redirect.
- call  in  1  call instruction retired.
- call_target  in  AW  callee address.
- ret  in  1  return instruction retired.
- trap  in  1  exception request.
- address  out  AW  current PC (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky; set when a push overwrote the oldest entry.
- ras_underflow  out  1  one-cycle pulse; ret issued on an empty RAS.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - address=RESET_VEC, ras_count=0, ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - Reset mid-operation discards all pending state immediately.
- Outputs are registered. There are no delay statements in RTL. A change on the inputs is visible on address the cycle after the qualifying edge (latency 1).
- Next-PC priority, evaluated at each rising edge, highest first:
  1. trap=1: address<=TRAP_VEC regardless of hit; RAS unchanged.
  2. hit=0: hold address and RAS; redirect/call/ret are ignored (the upstream block re-presents them).
  3. redirect=1: address<=redirect_target; call and ret ignored.
  4. call=1 and ret=1 together: replace the top entry with address+INC, address<=call_target; ras_count unchanged. If RAS is empty, this acts as a plain call.
  5. call=1: push address+INC, address<=call_target.
     - If ras_count==RAS_DEPTH, the push overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, and ras_overflow<=1 (cleared only by reset).
  6. ret=1, RAS non-empty: address<=top entry; pop; ras_count-1.
  7. ret=1, RAS empty: address<=TRAP_VEC; ras_underflow<=1 for exactly one cycle.
  8. Otherwise: address<=address+INC.
- Arithmetic: all additions are modulo 2^AW, so address wraps from 2^AW-INC to 0 silently.
- RAS organisation: top-of-stack pointer plus count.
  - Push writes at ptr+1 (mod RAS_DEPTH).
  - Pop reads at ptr, then decrements the pointer.
  - After an overflow, pops return the newest RAS_DEPTH entries in LIFO order.
- ras_underflow is deasserted on every edge where condition 7 does not hold.

Decomposition:
- Package pc_pkg holds:
  - default constants RESET_VEC_DEF and TRAP_VEC_DEF;
  - localparam helpers for the pointer and count widths;
  - a next-PC-source enum: SRC_TRAP, SRC_HOLD, SRC_REDIR, SRC_CALLRET, SRC_CALL, SRC_RET, SRC_RET_EMPTY, SRC_SEQ.
- One sub-module, pc_ras:
  - circular stack with push, pop, and replace strobes;
  - outputs top, count, overflow, empty.
- The top level contains the priority mux, the address register, and the underflow pulse.

Test Plan:
- Reset/sequential: rst_n low then high, hit=1 for 3 cycles -> address 0x0, 0x4, 0x8, 0xC; then hit=0 for 2 cycles -> address holds at 0xC.
- Redirect vs trap: at address 0x10 assert redirect=1 with target 0x200 -> next address 0x200. Assert trap=1 and redirect=1 together -> next address 0x80.
- Call/return nesting: from 0x100 call to 0x400; at 0x404 call to 0x800; then ret, ret -> address sequence 0x400, 0x404, 0x800, 0x408, 0x104; ras_count goes 1, 2, 1, 0.
- Overflow (RAS_DEPTH=4): 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_overflow=1, ras_count=4; 4 rets yield 0x44, 0x34, 0x24, 0x14; a 5th ret -> address 0x80 with ras_underflow pulsed for one cycle.
- Wrap and async reset: address 0xFFFF_FFFC with hit=1 -> address 0x0. Drop rst_n between clock edges -> address=RESET_VEC immediately, with no clock edge required.
- Simultaneous call+ret: RAS top 0x504, at address 0x600 assert both with call_target 0x900 -> address 0x900, top 0x604, ras_count unchanged.
